// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants used by the instruction encoder and the data generator.
// Holds the opcodes, the format enum and the 12-bit immediate range check.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;

   typedef enum logic [1:0] {
      FMT_I  = 2'd0,
      FMT_S  = 2'd1,
      FMT_SB = 2'd2,
      FMT_R  = 2'd3
   } fmt_e;

   // A 64-bit sign-extended value fits a 12-bit signed field when bits 63:11 all agree.
   function automatic logic imm_fits12(input logic [63:0] imm);
      return (imm[63:11] == '0) || (imm[63:11] == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and memory-write output channels of the instruction encoder.
// slave is the encoder's view, master is the producer/memory side.
interface instr_encoder_if;

   logic        in_valid;
   logic        in_ready;
   logic [1:0]  fmt;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [63:0] imm;

   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_addr;
   logic [31:0] out_data;

   modport slave (
      input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      output in_ready, out_valid, out_addr, out_data
   );

   modport master (
      output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      input  in_ready, out_valid, out_addr, out_data
   );

endinterface

// File: rtl/instr_pack.sv
// Purely combinational packing of decoded fields into a 32-bit instruction word.
// Also flags immediates that do not fit the 12-bit field of the I/S/SB formats.
module instr_pack
   import riscv_pkg::*;
(
   input  fmt_e        fmt,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [63:0] imm,
   output logic [31:0] word,
   output logic        range_err
);

   // Branch immediates arrive in halfword units, so imm[11] is the top bit of the offset.
   always_comb begin
      word      = '0;
      range_err = 1'b0;
      case (fmt)
         FMT_I: begin
            word      = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            range_err = !imm_fits12(imm);
         end
         FMT_S: begin
            word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            range_err = !imm_fits12(imm);
         end
         FMT_SB: begin
            word      = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OP_BRANCH};
            range_err = !imm_fits12(imm);
         end
         FMT_R: begin
            word      = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
         end
         default: begin
            word      = '0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs field bundles and writes them to consecutive addresses.
// One-entry output register with full-rate valid/ready handshakes on both sides.
module instr_encoder
   import riscv_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   instr_encoder_if.slave    bus,
   output logic              err,
   output logic [7:0]        err_count,
   output logic [15:0]       word_count
);

   logic        restart;
   logic        accept;
   logic        fire;
   logic [31:0] packed_word;
   logic        range_err;
   logic [63:0] next_addr;

   instr_pack u_pack (
      .fmt       (fmt_e'(bus.fmt)),
      .rd        (bus.rd),
      .rs1       (bus.rs1),
      .rs2       (bus.rs2),
      .funct3    (bus.funct3),
      .funct7    (bus.funct7),
      .imm       (bus.imm),
      .word      (packed_word),
      .range_err (range_err)
   );

   // The output slot is free when empty or being drained this cycle; restart blocks intake.
   assign restart      = reset || clear;
   assign bus.in_ready = !restart && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign fire         = bus.out_valid && bus.out_ready;

   // A rejected bundle is consumed but neither loads the slot nor advances the address.
   always_ff @(posedge clk) begin
      if (restart) begin
         bus.out_valid <= 1'b0;
         bus.out_addr  <= BASE_ADDR;
         bus.out_data  <= '0;
         next_addr     <= BASE_ADDR;
         err           <= 1'b0;
         err_count     <= '0;
         word_count    <= '0;
      end else begin
         err <= accept && range_err;
         if (accept && range_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
         if (fire) begin
            word_count <= word_count + 16'd1;
         end
         if (accept && !range_err) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= packed_word;
            bus.out_addr  <= next_addr;
            next_addr     <= next_addr + 64'd4;
         end else if (fire) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, range rejects, backpressure/clear,
// and a random run whose words are decoded back to the supplied immediate.
module tb_instr_encoder;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_1000;

   typedef struct {
      logic [63:0] addr;
      logic [1:0]  fmt;
      logic [63:0] imm;
      logic [24:0] regs;
      bit          exact;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        err;
   logic [7:0]  err_count;
   logic [15:0] word_count;

   exp_t        sbQ[$];
   logic [63:0] nextAddr;
   int          checkCount = 0;
   int          errorCount = 0;
   int          readyMode = 0;
   int          wordsDone = 0;
   int          wordBase = 0;
   int          errSeen = 0;
   int          errTotal = 0;
   int          errModel = 0;

   instr_encoder_if bus();

   instr_encoder #(.BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .bus        (bus),
      .err        (err),
      .err_count  (err_count),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic [6:0] expOpcode(input logic [1:0] f);
      case (f)
         2'd0:    return 7'b0000011;
         2'd1:    return 7'b0100011;
         2'd2:    return 7'b1100011;
         default: return 7'b0110011;
      endcase
   endfunction

   // Immediate data generator: recovers the sign-extended immediate from an encoded word.
   function automatic logic [63:0] decodeImm(input logic [1:0] f, input logic [31:0] w);
      logic [11:0] v;
      case (f)
         2'd0:    v = w[31:20];
         2'd1:    v = {w[31:25], w[11:7]};
         default: v = {w[31], w[7], w[30:25], w[11:8]};
      endcase
      return {{52{v[11]}}, v};
   endfunction

   function automatic logic [24:0] maskRegs(input logic [1:0] f, input logic [6:0] f7, input logic [4:0] r2,
                                            input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rdv);
      case (f)
         2'd0:    return {7'd0, 5'd0, r1, f3, rdv};
         2'd1,
         2'd2:    return {7'd0, r2, r1, f3, 5'd0};
         default: return {f7, r2, r1, f3, rdv};
      endcase
   endfunction

   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'b0;
         default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      exp_t e;
      logic [31:0] w;
      if (!reset && !clear) begin
         if (err) errSeen++;
         if (bus.out_valid && bus.out_ready) begin
            checkOutput("sb_nonempty", 64'(sbQ.size() > 0), 64'd1);
            if (sbQ.size() > 0) begin
               e = sbQ.pop_front();
               w = bus.out_data;
               wordsDone++;
               checkOutput("addr", bus.out_addr, e.addr);
               if (e.exact) begin
                  checkOutput("data", 64'(w), 64'(e.data));
               end else begin
                  checkOutput("opcode", 64'(w[6:0]), 64'(expOpcode(e.fmt)));
                  checkOutput("regs", 64'(maskRegs(e.fmt, w[31:25], w[24:20], w[19:15], w[14:12], w[11:7])),
                              64'(e.regs));
                  if (e.fmt != 2'd3) checkOutput("rt_imm", decodeImm(e.fmt, w), e.imm);
               end
            end
         end
      end
   end

   // Caller is positioned just after a rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input logic [1:0] f, input logic [4:0] rdv, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] immv, input bit exact, input logic [31:0] data);
      bit accepted = 0;
      exp_t e;
      bus.fmt = f; bus.rd = rdv; bus.rs1 = r1; bus.rs2 = r2;
      bus.funct3 = f3; bus.funct7 = f7; bus.imm = immv;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 200 && !accepted; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            accepted = 1;
            if (f == 2'd3 || immv[63:11] == '0 || immv[63:11] == '1) begin
               e.addr = nextAddr; e.fmt = f; e.imm = immv;
               e.regs = maskRegs(f, f7, r2, r1, f3, rdv);
               e.exact = exact; e.data = data;
               sbQ.push_back(e);
               nextAddr = nextAddr + 64'd4;
            end else begin
               errTotal++;
               if (errModel < 255) errModel++;
            end
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic waitDrain();
      bit done = 0;
      for (int c = 0; c < 2000 && !done; c++) begin
         @(negedge clk);
         if (sbQ.size() == 0 && !bus.out_valid) done = 1;
      end
      if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic setReady(input int m);
      readyMode = m;
      @(posedge clk); #2;
   endtask

   task automatic doClear();
      @(posedge clk); #1;
      clear = 1'b1;
      @(negedge clk);
      checkOutput("clear_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      clear = 1'b0;
      sbQ.delete();
      nextAddr = BASE;
      wordBase = wordsDone;
      errModel = 0;
      @(negedge clk);
      checkOutput("clr_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("clr_out_addr", bus.out_addr, BASE);
      checkOutput("clr_out_data", 64'(bus.out_data), 64'd0);
      checkOutput("clr_word_count", 64'(word_count), 64'd0);
      checkOutput("clr_err_count", 64'(err_count), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] saveData;
      logic [63:0] saveAddr;
      logic [11:0] i12;
      logic [63:0] immv;
      bus.in_valid = 1'b0; bus.fmt = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
      bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0; bus.out_ready = 1'b0;
      reset = 1'b1; clear = 1'b0; nextAddr = BASE;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_addr", bus.out_addr, BASE);
      checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_err_count", 64'(err_count), 64'd0);
      checkOutput("rst_word_count", 64'(word_count), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      applyStimulus(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 64'd8, 1, 32'h00813283);
      waitDrain();
      checkOutput("load_word_count", 64'(word_count), 64'd1);

      doClear();
      applyStimulus(2'd1, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, 64'd16, 1, 32'h00513823);
      applyStimulus(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'hFE208CE3);
      waitDrain();
      checkOutput("sb_word_count", 64'(word_count), 64'd2);

      applyStimulus(2'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1, 32'h002081B3);
      applyStimulus(2'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'h1000, 1, 32'h002081B3);
      waitDrain();
      checkOutput("r_err_seen", 64'(errSeen), 64'd0);
      checkOutput("r_err_count", 64'(err_count), 64'd0);

      applyStimulus(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 64'd2048, 1, 32'h0);
      waitDrain();
      checkOutput("range_err_seen", 64'(errSeen), 64'd1);
      checkOutput("range_err_count", 64'(err_count), 64'd1);
      applyStimulus(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd2047, 1, 32'h7FF08083);
      applyStimulus(2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_F800, 1, 32'h80000023);
      applyStimulus(2'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_F7FF, 1, 32'h0);
      waitDrain();
      checkOutput("edge_err_count", 64'(err_count), 64'd2);
      checkOutput("edge_word_count", 64'(word_count), 64'(wordsDone - wordBase));

      setReady(1);
      applyStimulus(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 64'd8, 1, 32'h00813283);
      @(negedge clk);
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_data", 64'(bus.out_data), 64'h00813283);
      saveData = bus.out_data;
      saveAddr = bus.out_addr;
      repeat (3) @(negedge clk);
      checkOutput("stall_data_hold", 64'(bus.out_data), 64'(saveData));
      checkOutput("stall_addr_hold", bus.out_addr, saveAddr);
      doClear();
      setReady(0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("post_clear_words", 64'(word_count), 64'd0);

      setReady(2);
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            immv = {$urandom(), $urandom()};
         end else begin
            i12 = 12'($urandom_range(0, 4095));
            immv = {{52{i12[11]}}, i12};
         end
         applyStimulus(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                       immv, 0, 32'h0);
      end
      setReady(0);
      waitDrain();
      checkOutput("rnd_word_count", 64'(word_count), 64'(16'(wordsDone - wordBase)));
      checkOutput("rnd_err_count", 64'(err_count), 64'(errModel));
      checkOutput("rnd_err_seen", 64'(errSeen), 64'(errTotal));

      for (int n = 0; n < 260; n++) begin
         applyStimulus(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'h1000, 0, 32'h0);
      end
      waitDrain();
      checkOutput("sat_err_count", 64'(err_count), 64'd255);
      checkOutput("sat_err_seen", 64'(errSeen), 64'(errTotal));
      applyStimulus(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 64'd8, 1, 32'h00813283);
      waitDrain();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
